// File: rtl/mul_div_unit_pkg.sv
// Shared opcodes, FSM encodings and helpers for the multiply/divide unit.
package mul_div_unit_pkg;

   localparam int SIZE_MDOP = 3;

   localparam logic [SIZE_MDOP-1:0] MDOP_MULT  = 3'd0;
   localparam logic [SIZE_MDOP-1:0] MDOP_MULTU = 3'd1;
   localparam logic [SIZE_MDOP-1:0] MDOP_DIV   = 3'd2;
   localparam logic [SIZE_MDOP-1:0] MDOP_DIVU  = 3'd3;
   localparam logic [SIZE_MDOP-1:0] MDOP_MFHI  = 3'd4;
   localparam logic [SIZE_MDOP-1:0] MDOP_MFLO  = 3'd5;
   localparam logic [SIZE_MDOP-1:0] MDOP_MTHI  = 3'd6;
   localparam logic [SIZE_MDOP-1:0] MDOP_MTLO  = 3'd7;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_FIN  = 2'd3;

   // Signed variants work on magnitudes and fix the sign up at the end.
   function automatic logic is_signed_op(input logic [SIZE_MDOP-1:0] op);
      return (op == MDOP_MULT) || (op == MDOP_DIV);
   endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// EX-stage <-> multiply/divide unit bundle.
interface mul_div_unit_if import mul_div_unit_pkg::*; #(parameter int WIDTH = 32);
   logic                 Start;
   logic [SIZE_MDOP-1:0] MdOp;
   logic [WIDTH-1:0]     InputData1;
   logic [WIDTH-1:0]     InputData2;
   logic                 Flush;
   logic                 Busy;
   logic                 Done;
   logic [WIDTH-1:0]     HiOut;
   logic [WIDTH-1:0]     LoOut;

   modport master (output Start, MdOp, InputData1, InputData2, Flush,
                   input  Busy, Done, HiOut, LoOut);
   modport slave  (input  Start, MdOp, InputData1, InputData2, Flush,
                   output Busy, Done, HiOut, LoOut);
endinterface

// File: rtl/mul_div_unit_md_div_core.sv
// Restoring divider on unsigned magnitudes, one quotient bit per step.
module md_div_core #(parameter int WIDTH = 32) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);
   logic [WIDTH-1:0] dsr;
   logic [WIDTH:0]   trial;
   logic [WIDTH:0]   diff;

   // Shift next dividend bit into the partial remainder and try the subtract.
   always_comb begin
      trial = {remainder, quotient[WIDTH-1]};
      diff  = trial - {1'b0, dsr};
   end

   // Quotient register doubles as the dividend shifter.
   always_ff @(posedge clk) begin
      if (reset) begin
         quotient  <= '0;
         remainder <= '0;
         dsr       <= '0;
      end else if (load) begin
         quotient  <= dividend;
         remainder <= '0;
         dsr       <= divisor;
      end else if (step) begin
         if (!diff[WIDTH]) begin
            remainder <= diff[WIDTH-1:0];
            quotient  <= {quotient[WIDTH-2:0], 1'b1};
         end else begin
            remainder <= trial[WIDTH-1:0];
            quotient  <= {quotient[WIDTH-2:0], 1'b0};
         end
      end
   end
endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; MTHI/MTLO write directly.
module mul_div_unit import mul_div_unit_pkg::*; #(parameter int WIDTH = 32) (
   input logic           clk,
   input logic           reset,
   mul_div_unit_if.slave md
);
   localparam int CW = $clog2(WIDTH);

   logic [1:0]         state;
   logic [CW-1:0]      cnt;
   logic               busy, done;
   logic [WIDTH-1:0]   hi, lo;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   mcand;
   logic               is_div, neg_res, neg_rem, div0;
   logic [WIDTH-1:0]   dvd;

   logic               a_neg, b_neg, accept, last;
   logic [WIDTH-1:0]   a_mag, b_mag, quotient, remainder, quo_s, rem_s;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] mul_res;

   // Operand magnitudes, iteration control and signed result fix-up.
   always_comb begin
      accept  = (state == S_IDLE) && md.Start && !md.Flush;
      a_neg   = is_signed_op(md.MdOp) && md.InputData1[WIDTH-1];
      b_neg   = is_signed_op(md.MdOp) && md.InputData2[WIDTH-1];
      a_mag   = a_neg ? -md.InputData1 : md.InputData1;
      b_mag   = b_neg ? -md.InputData2 : md.InputData2;
      last    = (cnt == CW'(WIDTH-1));
      sum     = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? mcand : '0)};
      mul_res = neg_res ? -prod : prod;
      quo_s   = neg_res ? -quotient : quotient;
      rem_s   = neg_rem ? -remainder : remainder;
   end

   md_div_core #(.WIDTH(WIDTH)) u_div (
      .clk       (clk),
      .reset     (reset),
      .load      (accept && (md.MdOp == MDOP_DIV || md.MdOp == MDOP_DIVU)),
      .step      ((state == S_DIV) && !md.Flush),
      .dividend  (a_mag),
      .divisor   (b_mag),
      .quotient  (quotient),
      .remainder (remainder)
   );

   // Control FSM, shift-add multiplier and HI/LO write-back.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         cnt     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         hi      <= '0;
         lo      <= '0;
         prod    <= '0;
         mcand   <= '0;
         is_div  <= 1'b0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         div0    <= 1'b0;
         dvd     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  case (md.MdOp)
                     MDOP_MULT, MDOP_MULTU: begin
                        state   <= S_MUL;
                        busy    <= 1'b1;
                        cnt     <= '0;
                        prod    <= {{WIDTH{1'b0}}, b_mag};
                        mcand   <= a_mag;
                        neg_res <= a_neg ^ b_neg;
                        is_div  <= 1'b0;
                     end
                     MDOP_DIV, MDOP_DIVU: begin
                        state   <= S_DIV;
                        busy    <= 1'b1;
                        cnt     <= '0;
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        div0    <= (md.InputData2 == '0);
                        dvd     <= md.InputData1;
                        is_div  <= 1'b1;
                     end
                     MDOP_MTHI: hi <= md.InputData1;
                     MDOP_MTLO: lo <= md.InputData1;
                     default: ;
                  endcase
               end
            end
            S_MUL, S_DIV: begin
               if (md.Flush) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else begin
                  if (state == S_MUL) prod <= {sum, prod[WIDTH-1:1]};
                  cnt <= cnt + 1'b1;
                  if (last) state <= S_FIN;
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               if (!md.Flush) begin
                  done <= 1'b1;
                  if (!is_div) begin
                     {hi, lo} <= mul_res;
                  end else if (div0) begin
                     lo <= '1;
                     hi <= dvd;
                  end else begin
                     lo <= quo_s;
                     hi <= rem_s;
                  end
               end
            end
         endcase
      end
   end

   assign md.Busy  = busy;
   assign md.Done  = done;
   assign md.HiOut = hi;
   assign md.LoOut = lo;
endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit.
module tb_mul_div_unit;
   import mul_div_unit_pkg::*;
   localparam int W = 32;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   tests = 0;
   int   fails = 0;
   logic [2*W-1:0] sb[$];

   mul_div_unit_if #(.WIDTH(W)) md();
   mul_div_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .md(md));

   always #5 clk = ~clk;

   // Reference model for randomised traffic.
   function automatic logic [2*W-1:0] model(input logic [SIZE_MDOP-1:0] op,
                                            input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] q, r;
      longint sp;
      case (op)
         MDOP_MULT: begin
            sp = longint'($signed(a)) * longint'($signed(b));
            return sp;
         end
         MDOP_MULTU: return {32'd0, a} * {32'd0, b};
         MDOP_DIV: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, a};
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            return {r, q};
         end
         default: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   // Scoreboard: every Done pops one expected {HI,LO}.
   always @(negedge clk) begin
      if (md.Done) begin
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_done: HI=%h LO=%h, no result expected", md.HiOut, md.LoOut);
         end else begin
            logic [2*W-1:0] e;
            e = sb.pop_front();
            if ({md.HiOut, md.LoOut} !== e)
               begin
                  fails++;
                  $display("FAIL result: got HI=%h LO=%h, expected HI=%h LO=%h",
                           md.HiOut, md.LoOut, e[2*W-1:W], e[W-1:0]);
               end
         end
      end
   end

   // One-cycle Start pulse at the next edge; returns at the negedge after it.
   task automatic drive(input logic [SIZE_MDOP-1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic fl);
      md.Start = 1'b1; md.MdOp = op; md.InputData1 = a; md.InputData2 = b; md.Flush = fl;
      @(negedge clk);
      md.Start = 1'b0; md.Flush = 1'b0;
   endtask

   // Counts edges from the Start edge to Done, and Busy cycles in between.
   task automatic wait_done(output int k, output int bcnt);
      k = 0; bcnt = 0;
      while (!md.Done && k < 60) begin
         if (md.Busy) bcnt++;
         @(negedge clk);
         k++;
      end
      if (!md.Done) begin
         tests++; fails++;
         $display("FAIL done_timeout: no Done after %0d cycles, expected 33", k);
      end
   endtask

   task automatic test_reset();
      @(negedge clk); @(negedge clk);
      tests++;
      if ({md.Busy, md.Done, md.HiOut, md.LoOut} !== '0) begin
         fails++;
         $display("FAIL reset_state: Busy=%b Done=%b HI=%h LO=%h, expected all 0",
                  md.Busy, md.Done, md.HiOut, md.LoOut);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_multu_latency();
      int k, bc;
      sb.push_back(64'hFFFF_FFFE_0000_0001);
      drive(MDOP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      wait_done(k, bc);
      tests++;
      if (k !== 33) begin fails++; $display("FAIL latency: Done at %0d, expected 33", k); end
      tests++;
      if (bc !== 33) begin fails++; $display("FAIL busy_len: Busy %0d cycles, expected 33", bc); end
      @(negedge clk);
      tests++;
      if (md.Busy !== 1'b0 || md.Done !== 1'b0) begin
         fails++; $display("FAIL post_done: Busy=%b Done=%b, expected 0 0", md.Busy, md.Done);
      end
   endtask

   task automatic test_directed();
      logic [SIZE_MDOP-1:0] ops[9];
      logic [W-1:0]         as[9], bs[9];
      logic [2*W-1:0]       ex[9];
      int k, bc;
      ops = '{MDOP_MULT, MDOP_DIV, MDOP_DIVU, MDOP_DIV, MDOP_DIV, MDOP_DIVU,
              MDOP_MULT, MDOP_DIV, MDOP_DIV};
      as  = '{32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd100, 32'd5, 32'h8000_0000, 32'h1234_5678,
              32'h8000_0000, 32'hFFFF_FFF9, 32'd7};
      bs  = '{32'd7, 32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd0,
              32'h8000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
      ex  = '{64'hFFFF_FFFF_FFFF_FFEB, 64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0002_0000_000E,
              64'h0000_0005_FFFF_FFFF, 64'h0000_0000_8000_0000, 64'h1234_5678_FFFF_FFFF,
              64'h4000_0000_0000_0000, 64'hFFFF_FFFF_0000_0003, 64'h0000_0001_FFFF_FFFD};
      for (int i = 0; i < 9; i++) begin
         sb.push_back(ex[i]);
         drive(ops[i], as[i], bs[i], 1'b0);
         wait_done(k, bc);
         @(negedge clk);
      end
   endtask

   task automatic test_mthi_mtlo();
      drive(MDOP_MTHI, 32'h1234, 32'd0, 1'b0);
      tests++;
      if (md.HiOut !== 32'h1234 || md.Busy !== 1'b0) begin
         fails++; $display("FAIL mthi: HI=%h Busy=%b, expected 00001234 0", md.HiOut, md.Busy);
      end
      drive(MDOP_MTLO, 32'h5678, 32'd0, 1'b0);
      tests++;
      if (md.LoOut !== 32'h5678 || md.HiOut !== 32'h1234 || md.Busy !== 1'b0) begin
         fails++; $display("FAIL mtlo: HI=%h LO=%h Busy=%b, expected 00001234 00005678 0",
                           md.HiOut, md.LoOut, md.Busy);
      end
      drive(MDOP_MFHI, 32'd0, 32'd0, 1'b0);
      tests++;
      if (md.Busy !== 1'b0 || {md.HiOut, md.LoOut} !== 64'h0000_1234_0000_5678) begin
         fails++; $display("FAIL mfhi: Busy=%b HI=%h LO=%h, expected no change", md.Busy, md.HiOut, md.LoOut);
      end
   endtask

   task automatic test_flush();
      bit seen = 0;
      drive(MDOP_MTHI, 32'hAA, 32'd0, 1'b0);
      drive(MDOP_MTLO, 32'hAA, 32'd0, 1'b0);
      drive(MDOP_MULT, 32'd5, 32'd6, 1'b0);
      repeat (10) @(negedge clk);
      md.Flush = 1'b1;
      @(negedge clk);
      md.Flush = 1'b0;
      tests++;
      if (md.Busy !== 1'b0) begin fails++; $display("FAIL flush_busy: Busy=%b, expected 0", md.Busy); end
      for (int i = 0; i < 40; i++) begin
         if (md.Done) seen = 1;
         @(negedge clk);
      end
      tests++;
      if (seen) begin fails++; $display("FAIL flush_done: Done seen=1, expected 0"); end
      tests++;
      if (md.HiOut !== 32'hAA || md.LoOut !== 32'hAA) begin
         fails++; $display("FAIL flush_hilo: HI=%h LO=%h, expected 000000aa 000000aa", md.HiOut, md.LoOut);
      end
      drive(MDOP_MTHI, 32'h55, 32'd0, 1'b1);
      tests++;
      if (md.HiOut !== 32'hAA) begin fails++; $display("FAIL flush_mthi: HI=%h, expected 000000aa", md.HiOut); end
      drive(MDOP_MULTU, 32'd3, 32'd4, 1'b1);
      tests++;
      if (md.Busy !== 1'b0) begin fails++; $display("FAIL flush_start: Busy=%b, expected 0", md.Busy); end
   endtask

   task automatic test_reset_mid();
      int k, bc;
      drive(MDOP_DIV, 32'd1000, 32'd3, 1'b0);
      repeat (20) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      tests++;
      if (md.Busy !== 1'b0 || md.HiOut !== '0 || md.LoOut !== '0) begin
         fails++; $display("FAIL reset_mid: Busy=%b HI=%h LO=%h, expected 0 0 0", md.Busy, md.HiOut, md.LoOut);
      end
      sb.push_back(model(MDOP_MULTU, 32'h0001_2345, 32'h0000_6789));
      drive(MDOP_MULTU, 32'h0001_2345, 32'h0000_6789, 1'b0);
      wait_done(k, bc);
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int k, bc;
      logic [SIZE_MDOP-1:0] op;
      logic [W-1:0] a, b;
      for (int i = 0; i < 12; i++) begin
         op = SIZE_MDOP'($urandom_range(0, 3));
         a  = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
         case ($urandom_range(0, 3))
            0:       b = 32'd0;
            1:       b = $urandom_range(1, 20);
            2:       b = 32'hFFFF_FFFF;
            default: b = $urandom;
         endcase
         sb.push_back(model(op, a, b));
         drive(op, a, b, 1'b0);
         wait_done(k, bc);
      end
      @(negedge clk);
   endtask

   initial begin
      md.Start = 1'b0; md.MdOp = '0; md.InputData1 = '0; md.InputData2 = '0; md.Flush = 1'b0;
      test_reset();
      test_multu_latency();
      test_directed();
      test_mthi_mtlo();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      repeat (3) @(negedge clk);
      tests++;
      if (sb.size() !== 0) begin
         fails++; $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
